// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared constants and types for the USB full-speed transmit encoder.
//   - tx_state_t : transmit state machine encoding
//   - SYNC_BYTE, STUFF_LIMIT, bit periods (8/8/9 clocks -> 25 clocks per 3 bits)
//   - LINE_* : {d_plus, d_minus} line encodings
//   - nrzi()       : next line state for one NRZI-encoded bit
//   - bit_period() : clocks in the bit period for a given timer phase
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    localparam logic [3:0] PERIOD_0 = 4'd8;
    localparam logic [3:0] PERIOD_1 = 4'd8;
    localparam logic [3:0] PERIOD_2 = 4'd9;

    // {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // A 1 holds the line, a 0 toggles J/K.
    function automatic logic [1:0] nrzi(input logic [1:0] line, input logic b);
        logic [1:0] r;
        if (b) r = line;
        else   r = (line == LINE_J) ? LINE_K : LINE_J;
        return r;
    endfunction

    function automatic logic [3:0] bit_period(input logic [1:0] phase);
        logic [3:0] p;
        case (phase)
            2'd0:    p = PERIOD_0;
            2'd1:    p = PERIOD_1;
            default: p = PERIOD_2;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// usb_tx_bit_timer: generates one bit_strobe per USB bit time, with periods
// cycling 8, 8, 9 clocks.
//   clk        in  system clock
//   rst        in  async active-high reset
//   clear      in  hold counter and phase at zero (phase 0 = 8-clock period)
//   enable     in  run the timer
//   bit_strobe out one cycle, the last clock of each bit period
module usb_tx_bit_timer
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_strobe
);

    logic [3:0] cnt;
    logic [1:0] phase;

    assign bit_strobe = enable && !clear && (cnt == bit_period(phase) - 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= '0;
        end else if (clear) begin
            cnt   <= '0;
            phase <= '0;
        end else if (bit_strobe) begin
            cnt   <= '0;
            phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        end else if (enable) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB full-speed transmit line encoder. Takes packet bytes over
// a valid/ready handshake, sends SYNC, bit-stuffs and NRZI-encodes the data
// LSB first, then ends the packet with SE0, SE0, J.
//   clk       in  system clock
//   rst       in  async active-high reset (line returns to J at once)
//   tx_data   in  [7:0] packet byte
//   tx_last   in  byte is the last of the packet
//   tx_valid  in  tx_data/tx_last valid
//   tx_ready  out holding register can take a byte
//   tx_busy   out packet in progress
//   tx_error  out one-cycle pulse on underrun
//   d_plus    out USB D+
//   d_minus   out USB D-
module usb_tx_encoder
    import usb_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_error,
    output logic       d_plus,
    output logic       d_minus
);

    tx_state_t  state, state_next;

    logic [7:0] hold_data;
    logic       hold_last;
    logic       hold_full;
    logic       last_seen;   // tx_last already accepted for this packet

    logic [7:0] shift;
    logic       cur_last;    // byte in the shift register carried tx_last
    logic [2:0] bit_idx;     // real bit currently on the line (or just before a stuffed slot)
    logic [2:0] ones_cnt;    // consecutive 1s sent, including the bit on the line
    logic       stuffing;    // current slot is a stuffed 0
    logic [1:0] line;

    logic strobe;
    logic timer_clear, timer_enable;
    logic accept;
    logic need_stuff, byte_end, nxt_bit;
    logic do_stuff, do_next, do_load, do_eop, do_error;

    assign timer_clear  = (state == IDLE);
    assign timer_enable = (state != IDLE);

    usb_tx_bit_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (timer_clear),
        .enable     (timer_enable),
        .bit_strobe (strobe)
    );

    assign tx_ready = !hold_full && !last_seen && (state inside {IDLE, SYNC, DATA});
    assign accept   = tx_valid && tx_ready;
    assign tx_busy  = (state != IDLE);
    assign d_plus   = line[1];
    assign d_minus  = line[0];

    // A stuffed slot never follows another, so only a real bit can trigger one.
    assign need_stuff = !stuffing && (ones_cnt == STUFF_LIMIT);
    assign byte_end   = (bit_idx == 3'd7);
    assign nxt_bit    = shift[bit_idx + 3'd1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_stuff   = 1'b0;
        do_next    = 1'b0;
        do_load    = 1'b0;
        do_eop     = 1'b0;
        do_error   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = SYNC;
            end
            SYNC, DATA: begin
                if (strobe) begin
                    // Pending stuff is sent before the byte boundary is taken.
                    if (need_stuff) begin
                        do_stuff = 1'b1;
                    end else if (!byte_end) begin
                        do_next = 1'b1;
                    end else if (state == SYNC) begin
                        do_load    = 1'b1;
                        state_next = DATA;
                    end else if (cur_last) begin
                        do_eop     = 1'b1;
                        state_next = EOP_SE0;
                    end else if (hold_full) begin
                        do_load = 1'b1;
                    end else begin
                        do_error   = 1'b1;
                        do_eop     = 1'b1;
                        state_next = EOP_SE0;
                    end
                end
            end
            EOP_SE0: begin
                if (strobe && bit_idx[0]) state_next = EOP_J;
            end
            EOP_J: begin
                if (strobe) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data <= '0;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
            last_seen <= 1'b0;
            shift     <= '0;
            cur_last  <= 1'b0;
            bit_idx   <= '0;
            ones_cnt  <= '0;
            stuffing  <= 1'b0;
            line      <= LINE_J;
            tx_error  <= 1'b0;
        end else begin
            tx_error <= do_error;

            // accept and load never coincide: tx_ready is low while full
            if (accept) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
                hold_full <= 1'b1;
                if (tx_last) last_seen <= 1'b1;
            end else if (do_load) begin
                hold_full <= 1'b0;
            end
            if (state == EOP_J && strobe) last_seen <= 1'b0;

            if (state == IDLE) begin
                if (accept) begin
                    // First SYNC bit goes out on the accept edge.
                    shift    <= SYNC_BYTE;
                    bit_idx  <= '0;
                    ones_cnt <= {2'b00, SYNC_BYTE[0]};
                    stuffing <= 1'b0;
                    line     <= nrzi(LINE_J, SYNC_BYTE[0]);
                end
            end else if (do_stuff) begin
                line     <= nrzi(line, 1'b0);
                ones_cnt <= '0;
                stuffing <= 1'b1;
            end else if (do_next) begin
                bit_idx  <= bit_idx + 3'd1;
                line     <= nrzi(line, nxt_bit);
                ones_cnt <= nxt_bit ? ones_cnt + 3'd1 : 3'd0;
                stuffing <= 1'b0;
            end else if (do_load) begin
                shift    <= hold_data;
                cur_last <= hold_last;
                bit_idx  <= '0;
                line     <= nrzi(line, hold_data[0]);
                // run length carries across the byte boundary
                ones_cnt <= hold_data[0] ? ones_cnt + 3'd1 : 3'd0;
                stuffing <= 1'b0;
            end else if (do_eop) begin
                line     <= LINE_SE0;
                bit_idx  <= '0;
                ones_cnt <= '0;
                stuffing <= 1'b0;
            end else if (state == EOP_SE0 && strobe) begin
                // bit_idx counts the two SE0 bit times
                if (bit_idx[0]) line    <= LINE_J;
                else            bit_idx <= 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: table-driven check of the USB TX encoder line output.
// Each vector lists the packet bytes and the expected symbol per bit time
// (J, K, 0 = SE0) from the SYNC edge to the return to IDLE.
module tb_usb_tx_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_error, d_plus, d_minus;

    int n_pass = 0;
    int n_total = 0;

    usb_tx_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_error (tx_error),
        .d_plus   (d_plus),
        .d_minus  (d_minus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][7:0] data;
        logic [3:0]      n;
        logic            last;
        logic [1:0]      exp_err;
        logic            chk_ready;
        logic [639:0]    exp;
    } vec_t;

    localparam int NVEC = 6;
    vec_t tbl [NVEC];

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    function automatic int slen(input logic [639:0] s);
        int n = 0;
        for (int i = 0; i < 80; i++) if (s[8*i +: 8] != 8'h00) n = i + 1;
        return n;
    endfunction

    function automatic logic [7:0] exp_char(input logic [639:0] s, input int len, input int j);
        return s[8*(len-1-j) +: 8];
    endfunction

    function automatic logic [7:0] sym(input logic [1:0] l);
        logic [7:0] c;
        case (l)
            2'b10:   c = "J";
            2'b01:   c = "K";
            2'b00:   c = "0";
            default: c = "X";
        endcase
        return c;
    endfunction

    // Feeds bytes 1..n-1 as tx_ready allows. Entered at a negedge.
    task automatic feed_rest(input int id, input vec_t v);
        logic acc;
        tx_valid = 1'b0;
        for (int i = 1; i < int'(v.n); i++) begin
            tx_data  = v.data[i];
            tx_last  = (i == int'(v.n) - 1) && v.last;
            tx_valid = 1'b1;
            acc = 1'b0;
            for (int w = 0; w < 300 && !acc; w++) begin
                if (tx_ready) begin
                    @(posedge clk);
                    @(negedge clk);
                    acc = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
            tx_valid = 1'b0;
            tx_last  = 1'b0;
            check($sformatf("vec%0d byte%0d accepted", id, i), int'(acc), 1);
        end
    endtask

    // Samples every clock of every bit time; bit k lasts 8/8/9 clocks by k%3.
    // Entered at the negedge just after the SYNC edge.
    task automatic capture(input int id, input vec_t v);
        int         len, nbits, errs, p;
        logic [1:0] s1;
        logic       stable, ok, done;
        logic [7:0] got, want;
        len = slen(v.exp);
        nbits = 0; errs = 0; ok = 1'b1; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            p = (k % 3 == 2) ? 9 : 8;
            s1 = {d_plus, d_minus};
            stable = 1'b1;
            if (tx_error) errs++;
            for (int c = 1; c < p; c++) begin
                @(negedge clk);
                if ({d_plus, d_minus} != s1) stable = 1'b0;
                if (tx_error) errs++;
            end
            if (v.chk_ready && k == 7)
                check($sformatf("vec%0d ready_before_load", id), int'(tx_ready), 0);
            if (ok) begin
                if (stable) got = sym(s1);
                else        got = "?";
                if (k < len) want = exp_char(v.exp, len, k);
                else         want = "-";
                if (got != want) begin
                    ok = 1'b0;
                    $display("FAIL vec%0d line bit %0d: got %c, want %c", id, k, got, want);
                end
            end
            @(negedge clk);
            nbits = k + 1;
            if (v.chk_ready && k == 7)
                check($sformatf("vec%0d ready_after_load", id), int'(tx_ready), 1);
            if (v.chk_ready && k == 15)
                check($sformatf("vec%0d ready_after_last", id), int'(tx_ready), 0);
            if (!tx_busy) done = 1'b1;
        end
        n_total++;
        if (ok) n_pass++;
        check($sformatf("vec%0d bit_times", id), nbits, len);
        check($sformatf("vec%0d tx_error_cycles", id), errs, int'(v.exp_err));
    endtask

    // Entered at a negedge with the DUT idle.
    task automatic run_packet(input int id);
        vec_t v;
        v = tbl[id];
        tx_data  = v.data[0];
        tx_last  = (v.n == 4'd1) && v.last;
        tx_valid = 1'b1;
        check($sformatf("vec%0d ready_idle", id), int'(tx_ready), 1);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d busy_start", id), int'(tx_busy), 1);
        check($sformatf("vec%0d line_k_start", id), int'({d_plus, d_minus}), 1);
        fork
            feed_rest(id, v);
            capture(id, v);
        join
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NVEC; i++) tbl[i] = '0;
        // 00: plain NRZI toggling
        tbl[0].n = 4'd1; tbl[0].last = 1'b1; tbl[0].data[0] = 8'h00;
        tbl[0].exp = 640'({"KJKJKJKK", "JKJKJKJK", "00J"});
        // FF: SYNC's trailing 1 plus five data 1s forces a stuff
        tbl[1].n = 4'd1; tbl[1].last = 1'b1; tbl[1].data[0] = 8'hFF;
        tbl[1].exp = 640'({"KJKJKJKK", "KKKKKJJJJ", "00J"});
        // C3, 3C back to back
        tbl[2].n = 4'd2; tbl[2].last = 1'b1; tbl[2].chk_ready = 1'b1;
        tbl[2].data[0] = 8'hC3; tbl[2].data[1] = 8'h3C;
        tbl[2].exp = 640'({"KJKJKJKK", "KKJKJKKK", "JKKKKKJK", "00J"});
        // A5 with no tx_last and nothing following: underrun
        tbl[3].n = 4'd1; tbl[3].last = 1'b0; tbl[3].exp_err = 2'd1; tbl[3].data[0] = 8'hA5;
        tbl[3].exp = 640'({"KJKJKJKK", "KJJKJJKK", "00J"});
        // seven 7F: a stuff in every byte, counter reset by each stuffed 0
        tbl[4].n = 4'd7; tbl[4].last = 1'b1;
        for (int i = 0; i < 7; i++) tbl[4].data[i] = 8'h7F;
        tbl[4].exp = 640'({"KJKJKJKK", "KKKKKJJJK", {6{"KKKKKKJJK"}}, "00J"});
        // FC: six 1s end on bit 7, stuff sits between last data bit and EOP
        tbl[5].n = 4'd1; tbl[5].last = 1'b1; tbl[5].data[0] = 8'hFC;
        tbl[5].exp = 640'({"KJKJKJKK", "JKKKKKKKJ", "00J"});

        repeat (3) @(negedge clk);
        check("reset d_plus", int'(d_plus), 1);
        check("reset d_minus", int'(d_minus), 0);
        check("reset tx_ready", int'(tx_ready), 1);
        check("reset tx_busy", int'(tx_busy), 0);
        check("reset tx_error", int'(tx_error), 0);
        rst = 1'b0;
        @(negedge clk);

        // reset in the middle of SYNC
        tx_data = 8'h00; tx_last = 1'b1; tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0; tx_last = 1'b0;
        check("midreset busy_before", int'(tx_busy), 1);
        repeat (40) @(negedge clk);
        check("midreset line_before", int'({d_plus, d_minus}), 1);
        #2 rst = 1'b1;
        #1;
        check("midreset line_j", int'({d_plus, d_minus}), 2);
        check("midreset busy", int'(tx_busy), 0);
        check("midreset ready", int'(tx_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("after_reset busy", int'(tx_busy), 0);
        check("after_reset line_j", int'({d_plus, d_minus}), 2);

        for (int i = 0; i < NVEC; i++) run_packet(i);

        repeat (2) @(negedge clk);
        check("end ready", int'(tx_ready), 1);
        check("end line_j", int'({d_plus, d_minus}), 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
